// File: rtl/sim_monitor_pkg.sv
// rtl/sim_monitor_pkg.sv - shared types and default constants for the DM1 observer tap
package sim_monitor_pkg;

  localparam int                   DM_ADDR_W      = 14;
  localparam logic [DM_ADDR_W-1:0] TEST_START_DEF = 14'h2000;
  localparam logic [DM_ADDR_W-1:0] END_ADDR_DEF   = 14'h3fff;
  localparam logic [31:0]          END_CODE_DEF   = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DM_ADDR_W-1:0] addr;
    logic [31:0]          data;
    logic [3:0]           be;
  } trace_entry_t;

endpackage

// File: rtl/sim_monitor_if.sv
// rtl/sim_monitor_if.sv - DM1 SRAM port observation and trace stream bundle
interface sim_monitor_if #(
  parameter int ADDR_W = 14
);

  logic              dm_ceb;
  logic [3:0]        dm_web;
  logic [ADDR_W-1:0] dm_a;
  logic [31:0]       dm_di;

  logic              trace_valid;
  logic              trace_ready;
  logic [ADDR_W-1:0] trace_addr;
  logic [31:0]       trace_data;
  logic [3:0]        trace_be;

  modport master (
    output dm_ceb, dm_web, dm_a, dm_di, trace_ready,
    input  trace_valid, trace_addr, trace_data, trace_be
  );

  modport slave (
    input  dm_ceb, dm_web, dm_a, dm_di, trace_ready,
    output trace_valid, trace_addr, trace_data, trace_be
  );

endinterface

// File: rtl/sim_monitor_trace_fifo.sv
// rtl/sim_monitor_trace_fifo.sv - first-word-fallthrough FIFO of trace entries with sticky drop flag
module trace_fifo
  import sim_monitor_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  trace_entry_t entry_in,
  input  logic         ready,
  output logic         valid,
  output trace_entry_t head,
  output logic         overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  trace_entry_t     mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             empty;
  logic             full;
  logic             pop;
  logic             wr_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign valid = !empty;
  assign pop   = valid && ready;
  // a pop frees the slot in the same edge, so a push into a full FIFO still lands
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (push && !wr_en) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[PTR_W-1:0]] <= entry_in;
  end

  // storage is not reset; gating keeps the head at zero whenever nothing is queued
  assign head = valid ? mem[rd_ptr[PTR_W-1:0]] : '0;

endmodule

// File: rtl/sim_monitor.sv
// rtl/sim_monitor.sv - DM1 port observer: perf counters, result-store trace and end-of-sim detect
module sim_monitor
  import sim_monitor_pkg::*;
#(
  parameter int                ADDR_W       = DM_ADDR_W,
  parameter logic [ADDR_W-1:0] TEST_START   = TEST_START_DEF,
  parameter logic [ADDR_W-1:0] END_ADDR     = END_ADDR_DEF,
  parameter logic [31:0]       END_CODE     = END_CODE_DEF,
  parameter int                TRACE_DEPTH  = 8,
  parameter int                DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  sim_monitor_if.slave bus,
  input  logic        retire,
  output logic [63:0] cycle,
  output logic [63:0] instret,
  output logic [15:0] store_cnt,
  output logic        overflow,
  output logic        done
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES) + 1;

  state_e             state_q;
  state_e             state_d;
  logic [CNT_W-1:0]   drain_q;
  logic [CNT_W-1:0]   drain_d;
  logic               store;
  logic               trigger;
  logic               active;
  logic               push;
  trace_entry_t       entry_in;
  trace_entry_t       head;

  assign store   = !bus.dm_ceb && (bus.dm_web != 4'hF);
  assign active  = (state_q != DONE);
  // only a full-word write of the exact code ends the run; anything else is a plain store
  assign trigger = store && (bus.dm_web == 4'h0) &&
                   (bus.dm_a == END_ADDR) && (bus.dm_di == END_CODE);
  assign push    = store && (bus.dm_a >= TEST_START) && active;

  assign entry_in.addr = DM_ADDR_W'(bus.dm_a);
  assign entry_in.data = bus.dm_di;
  assign entry_in.be   = ~bus.dm_web;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      RUN: begin
        if (trigger) begin
          state_d = DRAIN;
          drain_d = CNT_W'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        if (drain_q == '0) state_d = DONE;
        else               drain_d = drain_q - 1'b1;
      end
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle     <= '0;
      instret   <= '0;
      store_cnt <= '0;
    end else if (active) begin
      cycle <= cycle + 64'd1;
      if (retire) instret <= instret + 64'd1;
      if (store && (store_cnt != 16'hFFFF)) store_cnt <= store_cnt + 16'd1;
    end
  end

  assign done = (state_q == DONE);

  trace_fifo #(
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .entry_in (entry_in),
    .ready    (bus.trace_ready),
    .valid    (bus.trace_valid),
    .head     (head),
    .overflow (overflow)
  );

  assign bus.trace_addr = ADDR_W'(head.addr);
  assign bus.trace_data = head.data;
  assign bus.trace_be   = head.be;

endmodule
